// File: rtl/counter_driver_pkg.sv
// Shared definitions for the counter control interface and its driver.
// Holds the 2-bit control encodings used by both the counter and the
// driver, plus the driver FSM state encoding.
package counter_driver_pkg;

    localparam int unsigned CTRL_W = 2;

    localparam logic [CTRL_W-1:0] CTRL_HOLD = 2'b00;
    localparam logic [CTRL_W-1:0] CTRL_INC  = 2'b01;
    localparam logic [CTRL_W-1:0] CTRL_DEC  = 2'b10;
    localparam logic [CTRL_W-1:0] CTRL_RST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_REPEAT = 2'b10
    } drv_state_e;

endpackage

// File: rtl/counter_driver_rise_detect.sv
// rise_detect: one-bit rising-edge detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   level      : synchronous input level
//   rise_c     : level & ~previous level (combinational)
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise_c
);

    logic prev_q;

    // Previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_c = level & ~prev_q;

endmodule

// File: rtl/counter_driver.sv
// counter_driver: turns level up/down requests and a clear pulse into
// single-cycle 2-bit counter commands with press-and-hold auto-repeat,
// saturating at 0 and MAX using a shadow copy of the counter value.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (shared with counter)
//   inc_req, dec_req : request levels, synchronous to clk
//   clr              : clear pulse, highest priority
//   control          : registered command (00 hold, 01 inc, 10 dec, 11 reset)
//   shadow           : registered mirror of the driven counter's value
//   at_max, at_min   : shadow == MAX / shadow == 0, combinational
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int unsigned W        = 4,
    parameter int unsigned MAX      = (2 ** W) - 1,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned RPT_CYC  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_req,
    input  logic         dec_req,
    input  logic         clr,
    output logic [1:0]   control,
    output logic [W-1:0] shadow,
    output logic         at_max,
    output logic         at_min
);

    localparam int unsigned TMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    drv_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            dir_inc_q, dir_inc_d;
    logic            arm_q;
    logic [1:0]      ctrl_d;
    logic [W-1:0]    shad_eff_c;
    logic            inc_rise_c, dec_rise_c;
    logic            dir_inc_c, dir_dec_c;
    logic            step_c;

    rise_detect u_rise_inc (
        .clk    (clk),
        .rst_n  (rst_n),
        .level  (inc_req),
        .rise_c (inc_rise_c)
    );

    rise_detect u_rise_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .level  (dec_req),
        .rise_c (dec_rise_c)
    );

    // Exactly one request high selects a direction; both or none is no request
    assign dir_inc_c = inc_req & ~dec_req;
    assign dir_dec_c = dec_req & ~inc_req;

    // Counter value once the command currently on the bus has been applied;
    // saturation is judged against this so back-to-back steps cannot overshoot
    always_comb begin
        shad_eff_c = shadow;
        case (control)
            CTRL_INC: shad_eff_c = shadow + W'(1);
            CTRL_DEC: shad_eff_c = shadow - W'(1);
            CTRL_RST: shad_eff_c = '0;
            default:  shad_eff_c = shadow;
        endcase
    end

    // Next-state, timer and command decode
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_inc_d = dir_inc_q;
        ctrl_d    = CTRL_HOLD;
        step_c    = 1'b0;

        if (clr) begin
            ctrl_d  = CTRL_RST;
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // arm_q masks the first edge after reset so a request
                    // already held through reset is not taken as a new press
                    if (arm_q && ((dir_inc_c && inc_rise_c) ||
                                  (dir_dec_c && dec_rise_c))) begin
                        step_c    = 1'b1;
                        dir_inc_d = dir_inc_c;
                        state_d   = ST_WAIT;
                        timer_d   = TW'(HOLD_CYC - 1);
                    end
                end
                ST_WAIT, ST_REPEAT: begin
                    if (!(dir_inc_q ? dir_inc_c : dir_dec_c)) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer_q == '0) begin
                        step_c  = 1'b1;
                        state_d = ST_REPEAT;
                        timer_d = TW'(RPT_CYC - 1);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase

            // Saturated steps still advance the FSM but issue hold
            if (step_c) begin
                if (dir_inc_d) begin
                    if (shad_eff_c < W'(MAX)) begin
                        ctrl_d = CTRL_INC;
                    end
                end else if (shad_eff_c != '0) begin
                    ctrl_d = CTRL_DEC;
                end
            end
        end
    end

    // State, timer, command and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            dir_inc_q <= 1'b0;
            arm_q     <= 1'b0;
            control   <= CTRL_HOLD;
            shadow    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dir_inc_q <= dir_inc_d;
            arm_q     <= 1'b1;
            control   <= ctrl_d;
            shadow    <= shad_eff_c;
        end
    end

    assign at_max = (shadow == W'(MAX));
    assign at_min = (shadow == '0);

endmodule

// File: tb/tb_counter_driver.sv
// Testbench for counter_driver with a behavioural counter alongside it.
module tb_counter_driver;
    import counter_driver_pkg::*;

    localparam int unsigned W    = 4;
    localparam int          MAX  = 15;
    localparam int          HOLD = 8;
    localparam int          RPT  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inc_req, dec_req, clr;
    logic [1:0]   control;
    logic [W-1:0] shadow;
    logic         at_max, at_min;
    logic [W-1:0] cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_val, m_age, m_hdir;
    bit m_active, m_armed, m_pi, m_pd;

    typedef struct {
        logic       inc;
        logic       dec;
        logic       clr;
        logic [1:0] ctrl;
        int         shd;
    } vec_t;

    vec_t vt[17];

    always #5 clk = ~clk;

    counter_driver #(.W(W), .MAX(MAX), .HOLD_CYC(HOLD), .RPT_CYC(RPT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_req (inc_req),
        .dec_req (dec_req),
        .clr     (clr),
        .control (control),
        .shadow  (shadow),
        .at_max  (at_max),
        .at_min  (at_min)
    );

    // The driven counter: shares the reset, follows the control codes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else begin
            case (control)
                CTRL_INC: cnt <= cnt + 4'd1;
                CTRL_DEC: cnt <= cnt - 4'd1;
                CTRL_RST: cnt <= '0;
                default:  cnt <= cnt;
            endcase
        end
    end

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_val = 0; m_age = 0; m_hdir = 0;
        m_active = 0; m_armed = 0; m_pi = 0; m_pd = 0;
    endfunction

    // Spec rules: step on a fresh press, again HOLD cycles later, then every
    // RPT cycles while the same single direction is held. m_val is the
    // counter's value once all issued commands have landed.
    function automatic void model_edge(input bit i, input bit d, input bit c,
                                       output int ec, output int es);
        int dir;
        bit step;
        dir  = (i && !d) ? 1 : ((d && !i) ? 2 : 0);
        step = 0;
        es   = m_val;
        ec   = 0;
        if (c) begin
            ec = 3; m_val = 0; m_active = 0;
        end else if (m_active) begin
            if (dir == m_hdir) begin
                m_age++;
                if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % RPT == 0)) step = 1;
            end else begin
                m_active = 0;
            end
        end else if (m_armed && ((dir == 1 && !m_pi) || (dir == 2 && !m_pd))) begin
            m_active = 1; m_hdir = dir; m_age = 0; step = 1;
        end
        if (step) begin
            if (m_hdir == 1 && m_val < MAX) begin ec = 1; m_val++; end
            else if (m_hdir == 2 && m_val > 0) begin ec = 2; m_val--; end
        end
        m_pi = i; m_pd = d; m_armed = 1;
    endfunction

    // One clock: drive, let the edge happen, compare against the model
    task automatic cyc(input logic i, input logic d, input logic c);
        int ec, es;
        inc_req = i; dec_req = d; clr = c;
        @(posedge clk);
        model_edge(i, d, c, ec, es);
        #1;
        chk("control", int'(control), ec);
        chk("shadow", int'(shadow), es);
        chk("at_max", int'(at_max), int'(es == MAX));
        chk("at_min", int'(at_min), int'(es == 0));
        chk("counter", int'(cnt), es);
    endtask

    task automatic do_reset();
        inc_req = 0; dec_req = 0; clr = 0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_control", int'(control), 0);
        chk("rst_shadow", int'(shadow), 0);
        chk("rst_at_min", int'(at_min), 1);
        chk("rst_at_max", int'(at_max), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // inc, dec, clr, expected control, expected shadow
        vt[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 2'b10, 2};
        vt[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1};
        vt[11] = '{1'b0, 1'b1, 1'b0, 2'b10, 1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 2'b00, 0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 0};
        vt[15] = '{1'b0, 1'b0, 1'b1, 2'b11, 0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 2'b00, 0};

        do_reset();
        cyc(0, 0, 0);

        // Taps, simultaneous requests, decrement saturation, clear
        for (int n = 0; n < 17; n++) begin
            cyc(vt[n].inc, vt[n].dec, vt[n].clr);
            chk($sformatf("vec%0d_ctrl", n), int'(control), int'(vt[n].ctrl));
            chk($sformatf("vec%0d_shadow", n), int'(shadow), vt[n].shd);
        end

        // Hold increment from 0: steps at relative edges 0, 8, 12, 16
        do_reset();
        cyc(0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 0);
            chk("hold_inc_ctrl", int'(control), (k == 0 || k == 8 || k == 12 || k == 16) ? 1 : 0);
        end
        cyc(0, 0, 0);
        chk("hold_inc_shadow", int'(shadow), 4);

        // Drive to saturation, then hold at MAX
        for (int k = 0; k < 70; k++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("sat_shadow", int'(shadow), 15);
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, 0);
            chk("sat_ctrl", int'(control), 0);
            chk("sat_at_max", int'(at_max), 1);
        end
        cyc(0, 0, 0);

        // Clear during REPEAT with shadow at 6
        do_reset();
        cyc(0, 0, 0);
        for (int k = 0; k < 26; k++) cyc(1, 0, 0);
        chk("pre_clr_shadow", int'(shadow), 6);
        cyc(1, 0, 1);
        chk("clr_ctrl", int'(control), 3);
        for (int k = 0; k < 15; k++) begin
            cyc(1, 0, 0);
            chk("post_clr_ctrl", int'(control), 0);
            chk("post_clr_shadow", int'(shadow), 0);
            chk("post_clr_cnt", int'(cnt), 0);
        end
        cyc(0, 0, 0);

        // Asynchronous reset between edges while in WAIT
        cyc(1, 0, 0);
        chk("wait_step", int'(control), 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_ctrl", int'(control), 0);
        chk("async_shadow", int'(shadow), 0);
        chk("async_cnt", int'(cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, 0);
            chk("post_rst_hold", int'(control), 0);
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("post_rst_press", int'(control), 1);
        cyc(0, 0, 0);

        // Randomized run against the model
        begin
            logic ri, rd, rc;
            ri = 0; rd = 0;
            for (int k = 0; k < 1500; k++) begin
                if ($urandom_range(0, 9) == 0) ri = ~ri;
                if ($urandom_range(0, 13) == 0) rd = ~rd;
                rc = ($urandom_range(0, 59) == 0);
                cyc(ri, rd, rc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
